// File: rtl/clock_pkg.sv
// Shared types and field widths for the HH:MM:SS time keeper.
// Holds the FSM state type, the time bundle and a range-check helper.
package clock_pkg;

    localparam int HOUR_W      = 5;
    localparam int MIN_W       = 6;
    localparam int SEC_W       = 6;
    localparam int MAX_MIN_SEC = 59;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_CHECK = 1'b1
    } tk_state_t;

    typedef struct packed {
        logic [HOUR_W-1:0] hours;
        logic [MIN_W-1:0]  minutes;
        logic [SEC_W-1:0]  seconds;
    } hms_t;

    // Full-width compares so an oversized field can never alias into range.
    function automatic logic hms_in_range(
        input hms_t              t,
        input logic [HOUR_W-1:0] hour_last
    );
        return (t.hours <= hour_last)
            && (t.minutes <= MIN_W'(MAX_MIN_SEC))
            && (t.seconds <= SEC_W'(MAX_MIN_SEC));
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// Ports: clk, reset (sync, active-high), en (count enable),
//        clear (restart count at 0), tick (high while count is last).
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == LAST);

    // clear wins over a coincident tick so a fresh load starts a full second.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/time_keeper.sv
// Cascaded HH:MM:SS time-of-day counter with 1 Hz prescaler and a
// validated set-time load port.
// Ports: clk, reset (sync, active-high), run_en (advance enable);
//        load handshake set_valid/set_ready with set_hours/minutes/seconds,
//        set_done / set_err result pulses;
//        hours/minutes/seconds time outputs (registered);
//        sec_tick, min_carry, day_wrap one-cycle event pulses.
module time_keeper
    import clock_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int HOURS_MAX = 23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_en,
    input  logic              set_valid,
    output logic              set_ready,
    input  logic [HOUR_W-1:0] set_hours,
    input  logic [MIN_W-1:0]  set_minutes,
    input  logic [SEC_W-1:0]  set_seconds,
    output logic              set_done,
    output logic              set_err,
    output logic [HOUR_W-1:0] hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [SEC_W-1:0]  seconds,
    output logic              sec_tick,
    output logic              min_carry,
    output logic              day_wrap
);

    localparam logic [HOUR_W-1:0] H_LAST = HOUR_W'(HOURS_MAX);
    localparam logic [MIN_W-1:0]  M_LAST = MIN_W'(MAX_MIN_SEC);
    localparam logic [SEC_W-1:0]  S_LAST = SEC_W'(MAX_MIN_SEC);

    tk_state_t state, state_nx;
    hms_t      now, adv, shadow;

    logic tick;
    logic tick_pending, pending_nx;
    logic shadow_ok;
    logic accept;
    logic do_load;
    logic do_reject;
    logic do_advance;
    logic wrap_s, wrap_m, wrap_h;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (run_en),
        .clear (do_load),
        .tick  (tick)
    );

    // Next time value if a second elapses now, with cascaded carries.
    always_comb begin
        wrap_s = (now.seconds == S_LAST);
        wrap_m = wrap_s && (now.minutes == M_LAST);
        wrap_h = wrap_m && (now.hours == H_LAST);
        adv = now;
        adv.seconds = wrap_s ? '0 : now.seconds + SEC_W'(1);
        if (wrap_s) begin
            adv.minutes = wrap_m ? '0 : now.minutes + MIN_W'(1);
        end
        if (wrap_m) begin
            adv.hours = wrap_h ? '0 : now.hours + HOUR_W'(1);
        end
    end

    // Load FSM and tick arbitration.
    always_comb begin
        state_nx   = state;
        set_ready  = 1'b0;
        accept     = 1'b0;
        do_load    = 1'b0;
        do_reject  = 1'b0;
        do_advance = 1'b0;
        pending_nx = tick_pending;
        shadow_ok  = hms_in_range(shadow, H_LAST);
        unique case (state)
            S_RUN: begin
                set_ready = 1'b1;
                accept    = set_valid;
                if (set_valid) begin
                    state_nx = S_CHECK;
                end
                // A held tick and a fresh one can only meet after a
                // frozen spell; apply one and keep the other queued.
                if (run_en && (tick || tick_pending)) begin
                    do_advance = 1'b1;
                    pending_nx = tick && tick_pending;
                end
            end
            S_CHECK: begin
                state_nx = S_RUN;
                if (shadow_ok) begin
                    do_load    = 1'b1;
                    pending_nx = 1'b0;
                end else begin
                    do_reject  = 1'b1;
                    pending_nx = tick_pending || tick;
                end
            end
            default: begin
                state_nx = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_RUN;
            tick_pending <= 1'b0;
            shadow       <= '0;
        end else begin
            state        <= state_nx;
            tick_pending <= pending_nx;
            if (accept) begin
                shadow <= '{hours:   set_hours,
                            minutes: set_minutes,
                            seconds: set_seconds};
            end
        end
    end

    // do_load and do_advance live in different states, never together.
    always_ff @(posedge clk) begin
        if (reset) begin
            now       <= '0;
            set_done  <= 1'b0;
            set_err   <= 1'b0;
            sec_tick  <= 1'b0;
            min_carry <= 1'b0;
            day_wrap  <= 1'b0;
        end else begin
            set_done  <= do_load;
            set_err   <= do_reject;
            sec_tick  <= do_advance;
            min_carry <= do_advance && wrap_s;
            day_wrap  <= do_advance && wrap_h;
            if (do_load) begin
                now <= shadow;
            end else if (do_advance) begin
                now <= adv;
            end
        end
    end

    assign hours   = now.hours;
    assign minutes = now.minutes;
    assign seconds = now.seconds;

endmodule
